triangle_assembler: RTL
=======================

Name: triangle_assembler

Overview:
- Sits directly downstream of the vertex-to-viewport projection stage.
- Consumes its stream of projected vertices (viewport x/y, z depth) and its short-circuit cull pulses, and groups consecutive vertices in threes into triangles.
- Drops any triangle that contains a culled vertex, computes each surviving triangle's screen bounding box, and hands the triangle to the rasteriser over a valid/ready handshake.

Parameters:
- X_WIDTH, 20, viewport x position width (unsigned)
- Y_WIDTH, 18, viewport y position width (unsigned)
- Z_WIDTH, 16, depth width (unsigned)
- CNT_WIDTH, 16, dropped-triangle counter width

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset; asynchronous, active-high
- vertex_valid_in  input  1  one-cycle pulse: projected vertex present on vertex_*_in
- vertex_cull_in  input  1  one-cycle pulse: upstream short-circuited (culled) one vertex
- vertex_x_in  input  X_WIDTH  viewport x
- vertex_y_in  input  Y_WIDTH  viewport y
- vertex_z_in  input  Z_WIDTH  depth
- ready_out  input-side  1  output; block can accept a vertex pulse this cycle (drives upstream ready_in)
- tri_valid_out  output  1  triangle available on tri_*/bbox_*
- tri_ready_in  input  1  rasteriser accepts triangle
- tri_x_out  output  3*X_WIDTH  packed [2:0] vertex x, index = arrival order
- tri_y_out  output  3*Y_WIDTH  packed [2:0] vertex y
- tri_z_out  output  3*Z_WIDTH  packed [2:0] vertex z
- bbox_x_min_out, bbox_x_max_out  output  X_WIDTH each  bounding box x
- bbox_y_min_out, bbox_y_max_out  output  Y_WIDTH each  bounding box y
- drop_count_out  output  CNT_WIDTH  triangles discarded since reset, saturating

Behaviour:
- Reset (async assert, sync deassert) sets:
  - tri_valid_out=0; all tri_*/bbox_* outputs=0; drop_count_out=0
  - collector slot=0, drop_flag=0, output stage empty; ready_out=1 after reset.
- Collector:
  - Slot counter 0..2 plus a drop_flag.
  - A vertex event is any cycle with vertex_cull_in=1, or vertex_valid_in=1 && ready_out=1.
  - vertex_valid_in while ready_out=0 is ignored; upstream holds in its HOLD state, so no data is lost.
  - vertex_cull_in is accepted in every state, independent of ready_out.
  - If vertex_valid_in and vertex_cull_in are both 1 in one cycle: cull wins, one slot consumed, data not stored.
  - On a valid vertex event, store x/y/z into the slot index and update a running min/max for x and y. Slot 0 initialises min=max=vertex.
  - On a cull event, set drop_flag.
  - On an event at slot 0 or 1: slot increments.
  - On an event at slot 2 (triangle complete):
    - if drop_flag or this event is a cull: discard, drop_count++ (saturate at all-ones), slot←0, drop_flag←0
    - else transfer vertices + bbox to the output stage, slot←0.
- Output stage: a single register.
  - Transfer allowed when the stage is empty, or when it is being drained this cycle (tri_valid_out && tri_ready_in).
- ready_out:
  - ready_out = !(slot==2 && !drop_flag && output_full).
  - Combinational from registers only; no combinational path from tri_ready_in.
  - With drop_flag set at slot 2 the triangle will be discarded, so ready_out stays 1.
- Handshake:
  - tri_valid_out rises the cycle after the completing vertex event (latency 1).
  - tri_valid_out holds, with stable data, until tri_ready_in=1; it falls next cycle unless a new triangle transfers in the same cycle (back-to-back allowed).
- Arithmetic: bbox comparisons are unsigned. Vertices from upstream are already in the range [0, VW) / [0, VH); no clamping.
- Reset asserted mid-triangle or with the output full: all partial and pending state is discarded immediately.

Optional Feature:
- Macro: BACKFACE_CULL_EN.
- Defined:
  - A CHECK register stage is inserted between collector and output.
  - It computes the signed double area (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0), signed width X_WIDTH+Y_WIDTH+3.
  - Triangles with area <= 0 (back-facing or degenerate) are discarded and counted in drop_count_out.
  - Latency becomes 2 cycles.
  - ready_out is also low when slot==2, !drop_flag, and the CHECK stage is occupied but blocked by a full output stage.
- Undefined: no area logic; latency 1; every uncensored triangle is emitted.

Test Plan:
- Vertices (10,20,5),(30,5,7),(20,40,9), tri_ready_in=1 → one tri_valid_out pulse 1 cycle after the third vertex (2 with macro); bbox x 10..30, y 5..40; tri_z_out={9,7,5}.
- Vertex, cull pulse, vertex → no output; drop_count_out=1; next three valid vertices emit a normal triangle (slot realignment correct).
- tri_ready_in=0 with a triangle held, then three more vertices → ready_out=0 at slot 2; data stable. Raise tri_ready_in → first triangle leaves, second follows back-to-back; no vertex lost.
- Simultaneous vertex_valid_in and vertex_cull_in at slot 2 → triangle dropped, drop_count_out increments by exactly 1.
- BACKFACE_CULL_EN: vertices (0,0),(10,0),(0,10) → area 100, emitted. Reversed order (0,0),(0,10),(10,0) → dropped. Collinear (0,0),(5,5),(10,10) → dropped.
- Assert rst_in asynchronously after two vertices with the output full → tri_valid_out drops without a clock edge; ready_out=1 after release; next three vertices form a fresh triangle.

Source files
------------

// File: rtl/triangle_assembler.sv
// Groups projected vertices into triangles, drops any triangle touching a culled vertex,
// computes the screen bounding box and hands triangles to the rasteriser.
// Optional BACKFACE_CULL_EN adds a CHECK stage that discards triangles with area <= 0.
//
// Collector states:
//   state | meaning
//   SLOT0 | waiting for first vertex of a triangle
//   SLOT1 | one vertex event seen
//   SLOT2 | two vertex events seen; next event completes the triangle
module triangle_assembler #(
    parameter int X_WIDTH   = 20,
    parameter int Y_WIDTH   = 18,
    parameter int Z_WIDTH   = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   vertex_valid_in,
    input  logic                   vertex_cull_in,
    input  logic [X_WIDTH-1:0]     vertex_x_in,
    input  logic [Y_WIDTH-1:0]     vertex_y_in,
    input  logic [Z_WIDTH-1:0]     vertex_z_in,
    output logic                   ready_out,
    output logic                   tri_valid_out,
    input  logic                   tri_ready_in,
    output logic [3*X_WIDTH-1:0]   tri_x_out,
    output logic [3*Y_WIDTH-1:0]   tri_y_out,
    output logic [3*Z_WIDTH-1:0]   tri_z_out,
    output logic [X_WIDTH-1:0]     bbox_x_min_out,
    output logic [X_WIDTH-1:0]     bbox_x_max_out,
    output logic [Y_WIDTH-1:0]     bbox_y_min_out,
    output logic [Y_WIDTH-1:0]     bbox_y_max_out,
    output logic [CNT_WIDTH-1:0]   drop_count_out
);

    typedef enum logic [1:0] {SLOT0, SLOT1, SLOT2} slot_e;

    slot_e                 slot_q, slot_d;
    logic                  drop_flag_q, drop_flag_d;
    logic [X_WIDTH-1:0]    x0_q, x0_d, x1_q, x1_d;
    logic [Y_WIDTH-1:0]    y0_q, y0_d, y1_q, y1_d;
    logic [Z_WIDTH-1:0]    z0_q, z0_d, z1_q, z1_d;
    logic [X_WIDTH-1:0]    xmin_q, xmin_d, xmax_q, xmax_d;
    logic [Y_WIDTH-1:0]    ymin_q, ymin_d, ymax_q, ymax_d;

    logic                  out_valid_q, out_valid_d;
    logic [3*X_WIDTH-1:0]  out_x_q, out_x_d;
    logic [3*Y_WIDTH-1:0]  out_y_q, out_y_d;
    logic [3*Z_WIDTH-1:0]  out_z_q, out_z_d;
    logic [X_WIDTH-1:0]    out_xmin_q, out_xmin_d, out_xmax_q, out_xmax_d;
    logic [Y_WIDTH-1:0]    out_ymin_q, out_ymin_d, out_ymax_q, out_ymax_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

    logic                  cull_ev, vld_ev, any_ev, complete, coll_drop, coll_xfer;
    logic [X_WIDTH-1:0]    nx_min, nx_max;
    logic [Y_WIDTH-1:0]    ny_min, ny_max;
    logic [3*X_WIDTH-1:0]  asm_x;
    logic [3*Y_WIDTH-1:0]  asm_y;
    logic [3*Z_WIDTH-1:0]  asm_z;
    logic                  out_load;
    logic [1:0]            drop_inc;
    logic [CNT_WIDTH:0]    drop_sum;

    // A blocked CHECK stage implies a full output stage, so out_valid_q covers both cases.
    assign ready_out = !((slot_q == SLOT2) && !drop_flag_q && out_valid_q);

    assign cull_ev   = vertex_cull_in;
    assign vld_ev    = vertex_valid_in && ready_out && !vertex_cull_in;
    assign any_ev    = cull_ev || vld_ev;
    assign complete  = any_ev && (slot_q == SLOT2);
    assign coll_drop = complete && (drop_flag_q || cull_ev);
    assign coll_xfer = complete && !coll_drop;

    assign nx_min = ((slot_q == SLOT0) || (vertex_x_in < xmin_q)) ? vertex_x_in : xmin_q;
    assign nx_max = ((slot_q == SLOT0) || (vertex_x_in > xmax_q)) ? vertex_x_in : xmax_q;
    assign ny_min = ((slot_q == SLOT0) || (vertex_y_in < ymin_q)) ? vertex_y_in : ymin_q;
    assign ny_max = ((slot_q == SLOT0) || (vertex_y_in > ymax_q)) ? vertex_y_in : ymax_q;

    assign asm_x = {vertex_x_in, x1_q, x0_q};
    assign asm_y = {vertex_y_in, y1_q, y0_q};
    assign asm_z = {vertex_z_in, z1_q, z0_q};

`ifdef BACKFACE_CULL_EN
    localparam int AW = X_WIDTH + Y_WIDTH + 3;

    function automatic logic signed [AW-1:0] sx(input logic [X_WIDTH-1:0] v);
        return $signed({{(AW-X_WIDTH){1'b0}}, v});
    endfunction

    function automatic logic signed [AW-1:0] sy(input logic [Y_WIDTH-1:0] v);
        return $signed({{(AW-Y_WIDTH){1'b0}}, v});
    endfunction

    logic                  chk_valid_q, chk_valid_d;
    logic [3*X_WIDTH-1:0]  chk_x_q, chk_x_d;
    logic [3*Y_WIDTH-1:0]  chk_y_q, chk_y_d;
    logic [3*Z_WIDTH-1:0]  chk_z_q, chk_z_d;
    logic [X_WIDTH-1:0]    chk_xmin_q, chk_xmin_d, chk_xmax_q, chk_xmax_d;
    logic [Y_WIDTH-1:0]    chk_ymin_q, chk_ymin_d, chk_ymax_q, chk_ymax_d;
    logic signed [AW-1:0]  area;
    logic                  chk_kill, chk_move;

    assign area = (sx(chk_x_q[X_WIDTH +: X_WIDTH]) - sx(chk_x_q[0 +: X_WIDTH]))
                * (sy(chk_y_q[2*Y_WIDTH +: Y_WIDTH]) - sy(chk_y_q[0 +: Y_WIDTH]))
                - (sx(chk_x_q[2*X_WIDTH +: X_WIDTH]) - sx(chk_x_q[0 +: X_WIDTH]))
                * (sy(chk_y_q[Y_WIDTH +: Y_WIDTH]) - sy(chk_y_q[0 +: Y_WIDTH]));
    assign chk_kill = chk_valid_q && (area[AW-1] || (area == '0));
    assign chk_move = chk_valid_q && !chk_kill && (!out_valid_q || tri_ready_in);
    assign out_load = chk_move;
    assign drop_inc = {1'b0, coll_drop} + {1'b0, chk_kill};
`else
    assign out_load = coll_xfer;
    assign drop_inc = {1'b0, coll_drop};
`endif

    assign drop_sum = {1'b0, drop_cnt_q} + {{(CNT_WIDTH-1){1'b0}}, drop_inc};

    always_comb begin
        slot_d      = slot_q;
        drop_flag_d = drop_flag_q;
        x0_d = x0_q;  x1_d = x1_q;
        y0_d = y0_q;  y1_d = y1_q;
        z0_d = z0_q;  z1_d = z1_q;
        xmin_d = xmin_q;  xmax_d = xmax_q;
        ymin_d = ymin_q;  ymax_d = ymax_q;
        out_valid_d = out_valid_q;
        out_x_d = out_x_q;  out_y_d = out_y_q;  out_z_d = out_z_q;
        out_xmin_d = out_xmin_q;  out_xmax_d = out_xmax_q;
        out_ymin_d = out_ymin_q;  out_ymax_d = out_ymax_q;
        drop_cnt_d = drop_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : drop_sum[CNT_WIDTH-1:0];

        if (vld_ev && (slot_q != SLOT2)) begin
            xmin_d = nx_min;  xmax_d = nx_max;
            ymin_d = ny_min;  ymax_d = ny_max;
            if (slot_q == SLOT0) begin
                x0_d = vertex_x_in;  y0_d = vertex_y_in;  z0_d = vertex_z_in;
            end else begin
                x1_d = vertex_x_in;  y1_d = vertex_y_in;  z1_d = vertex_z_in;
            end
        end

        if (cull_ev) drop_flag_d = 1'b1;

        if (any_ev) begin
            case (slot_q)
                SLOT0:   slot_d = SLOT1;
                SLOT1:   slot_d = SLOT2;
                default: begin
                    slot_d      = SLOT0;
                    drop_flag_d = 1'b0;
                end
            endcase
        end

        if (out_valid_q && tri_ready_in) out_valid_d = 1'b0;

`ifdef BACKFACE_CULL_EN
        chk_valid_d = chk_valid_q;
        chk_x_d = chk_x_q;  chk_y_d = chk_y_q;  chk_z_d = chk_z_q;
        chk_xmin_d = chk_xmin_q;  chk_xmax_d = chk_xmax_q;
        chk_ymin_d = chk_ymin_q;  chk_ymax_d = chk_ymax_q;
        if (chk_kill || chk_move) chk_valid_d = 1'b0;
        if (coll_xfer) begin
            chk_valid_d = 1'b1;
            chk_x_d = asm_x;  chk_y_d = asm_y;  chk_z_d = asm_z;
            chk_xmin_d = nx_min;  chk_xmax_d = nx_max;
            chk_ymin_d = ny_min;  chk_ymax_d = ny_max;
        end
        if (out_load) begin
            out_valid_d = 1'b1;
            out_x_d = chk_x_q;  out_y_d = chk_y_q;  out_z_d = chk_z_q;
            out_xmin_d = chk_xmin_q;  out_xmax_d = chk_xmax_q;
            out_ymin_d = chk_ymin_q;  out_ymax_d = chk_ymax_q;
        end
`else
        if (out_load) begin
            out_valid_d = 1'b1;
            out_x_d = asm_x;  out_y_d = asm_y;  out_z_d = asm_z;
            out_xmin_d = nx_min;  out_xmax_d = nx_max;
            out_ymin_d = ny_min;  out_ymax_d = ny_max;
        end
`endif
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            slot_q      <= SLOT0;
            drop_flag_q <= 1'b0;
            x0_q <= '0;  x1_q <= '0;
            y0_q <= '0;  y1_q <= '0;
            z0_q <= '0;  z1_q <= '0;
            xmin_q <= '0;  xmax_q <= '0;
            ymin_q <= '0;  ymax_q <= '0;
            out_valid_q <= 1'b0;
            out_x_q <= '0;  out_y_q <= '0;  out_z_q <= '0;
            out_xmin_q <= '0;  out_xmax_q <= '0;
            out_ymin_q <= '0;  out_ymax_q <= '0;
            drop_cnt_q <= '0;
`ifdef BACKFACE_CULL_EN
            chk_valid_q <= 1'b0;
            chk_x_q <= '0;  chk_y_q <= '0;  chk_z_q <= '0;
            chk_xmin_q <= '0;  chk_xmax_q <= '0;
            chk_ymin_q <= '0;  chk_ymax_q <= '0;
`endif
        end else begin
            slot_q      <= slot_d;
            drop_flag_q <= drop_flag_d;
            x0_q <= x0_d;  x1_q <= x1_d;
            y0_q <= y0_d;  y1_q <= y1_d;
            z0_q <= z0_d;  z1_q <= z1_d;
            xmin_q <= xmin_d;  xmax_q <= xmax_d;
            ymin_q <= ymin_d;  ymax_q <= ymax_d;
            out_valid_q <= out_valid_d;
            out_x_q <= out_x_d;  out_y_q <= out_y_d;  out_z_q <= out_z_d;
            out_xmin_q <= out_xmin_d;  out_xmax_q <= out_xmax_d;
            out_ymin_q <= out_ymin_d;  out_ymax_q <= out_ymax_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef BACKFACE_CULL_EN
            chk_valid_q <= chk_valid_d;
            chk_x_q <= chk_x_d;  chk_y_q <= chk_y_d;  chk_z_q <= chk_z_d;
            chk_xmin_q <= chk_xmin_d;  chk_xmax_q <= chk_xmax_d;
            chk_ymin_q <= chk_ymin_d;  chk_ymax_q <= chk_ymax_d;
`endif
        end
    end

    assign tri_valid_out  = out_valid_q;
    assign tri_x_out      = out_x_q;
    assign tri_y_out      = out_y_q;
    assign tri_z_out      = out_z_q;
    assign bbox_x_min_out = out_xmin_q;
    assign bbox_x_max_out = out_xmax_q;
    assign bbox_y_min_out = out_ymin_q;
    assign bbox_y_max_out = out_ymax_q;
    assign drop_count_out = drop_cnt_q;

endmodule
